// File: rtl/mmu_pkg.sv
// Shared types for the MMU tile sequencer: MMU command encoding, sequencer states
// and the default array flush length.
package mmu_pkg;

  typedef enum logic [2:0] {
    CmdReset         = 3'd0,
    CmdTrigger       = 3'd1,
    CmdSetMulVal     = 3'd2,
    CmdSetAddVal     = 3'd3,
    CmdSetPeVal      = 3'd4,
    CmdSetConvMode   = 3'd5,
    CmdSetFixMacMode = 3'd6,
    CmdIdle          = 3'd7
  } mmu_cmd_e;

  typedef enum logic [2:0] {
    StIdle,
    StCfg,
    StClr,
    StFeed,
    StDrain,
    StWait,
    StDone
  } seq_state_e;

  // 3 cycles of operand skew plus 3 cycles of propagation through the 4x4 array.
  localparam int unsigned DRAIN_CYC_DEFAULT = 6;

endpackage

// File: rtl/mmu_seq.sv
// Tile sequencer for the 4x4 systolic MMU: sets the mode, clears the array, streams K operand
// columns as TRIGGER commands, flushes with zero TRIGGERs and pulses done once the MMU is idle.
module mmu_seq
  import mmu_pkg::*;
#(
  parameter int unsigned ACLEN      = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned AW         = 10,
  parameter int unsigned KW         = 16,
  parameter int unsigned DRAIN_CYC  = DRAIN_CYC_DEFAULT
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic                    mode_i,
  input  logic [KW-1:0]           k_i,
  input  logic [AW-1:0]           base_addr_i,
  output logic                    ready_o,
  output logic                    done_o,
  output logic                    buf_rd_en_o,
  output logic [AW-1:0]           buf_rd_addr_o,
  input  logic [4*DATA_WIDTH-1:0] buf_data_i,
  input  logic [4*DATA_WIDTH-1:0] buf_wgt_i,
  output logic                    mmu_cmd_valid,
  output logic [ACLEN:0]          mmu_cmd,
  output logic [DATA_WIDTH-1:0]   param_1_out,
  output logic [DATA_WIDTH-1:0]   param_2_out,
  output logic [DATA_WIDTH-1:0]   data_1_out,
  output logic [DATA_WIDTH-1:0]   data_2_out,
  output logic [DATA_WIDTH-1:0]   data_3_out,
  output logic [DATA_WIDTH-1:0]   data_4_out,
  output logic [DATA_WIDTH-1:0]   weight_1_out,
  output logic [DATA_WIDTH-1:0]   weight_2_out,
  output logic [DATA_WIDTH-1:0]   weight_3_out,
  output logic [DATA_WIDTH-1:0]   weight_4_out,
  input  logic                    mmu_busy
);

  seq_state_e    r_state, w_state_d;
  logic [KW-1:0] r_cnt, w_cnt_d;
  logic [AW-1:0] r_addr, w_addr_d;
  logic          r_mode, w_mode_d;
  logic          r_trig, r_trig_data;
  logic          w_feed, w_drain;
  mmu_cmd_e      w_cmd;

  assign w_feed  = (r_state == StFeed);
  assign w_drain = (r_state == StDrain);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_mode      <= 1'b0;
      r_trig      <= 1'b0;
      r_trig_data <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_addr      <= w_addr_d;
      r_mode      <= w_mode_d;
      // TRIGGER lags the read by one cycle so it lines up with the buffer read data.
      r_trig      <= w_feed | w_drain;
      r_trig_data <= w_feed;
    end
  end

  // r_cnt counts the remaining FEED reads, then is reused for the DRAIN cycles.
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_addr_d  = r_addr;
    w_mode_d  = r_mode;
    unique case (r_state)
      StIdle: begin
        if (start_i) begin
          w_cnt_d   = k_i;
          w_addr_d  = base_addr_i;
          w_mode_d  = mode_i;
          w_state_d = StCfg;
        end
      end
      StCfg: w_state_d = StClr;
      StClr: w_state_d = (r_cnt == '0) ? StDone : StFeed;
      StFeed: begin
        w_cnt_d  = r_cnt - 1'b1;
        w_addr_d = r_addr + 1'b1;
        if (r_cnt == KW'(1)) begin
          w_cnt_d   = KW'(DRAIN_CYC);
          w_state_d = StDrain;
        end
      end
      StDrain: begin
        w_cnt_d = r_cnt - 1'b1;
        if (r_cnt == KW'(1)) begin
          w_state_d = StWait;
        end
      end
      StWait: begin
        if (!mmu_busy) begin
          w_state_d = StDone;
        end
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_cmd         = CmdIdle;
    mmu_cmd_valid = 1'b0;
    if (r_state == StCfg) begin
      w_cmd         = r_mode ? CmdSetConvMode : CmdSetFixMacMode;
      mmu_cmd_valid = 1'b1;
    end else if (r_state == StClr) begin
      w_cmd         = CmdReset;
      mmu_cmd_valid = 1'b1;
    end else if (r_trig) begin
      w_cmd         = CmdTrigger;
      mmu_cmd_valid = 1'b1;
    end
  end

  assign mmu_cmd       = {{(ACLEN - 2){1'b0}}, w_cmd};
  assign ready_o       = (r_state == StIdle);
  assign done_o        = (r_state == StDone);
  assign buf_rd_en_o   = w_feed;
  assign buf_rd_addr_o = w_feed ? r_addr : '0;
  assign param_1_out   = '0;
  assign param_2_out   = '0;

  // Drain TRIGGERs push zeros; only TRIGGERs following a read pass operands through.
  assign data_1_out   = r_trig_data ? buf_data_i[0*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign data_2_out   = r_trig_data ? buf_data_i[1*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign data_3_out   = r_trig_data ? buf_data_i[2*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign data_4_out   = r_trig_data ? buf_data_i[3*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign weight_1_out = r_trig_data ? buf_wgt_i[0*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign weight_2_out = r_trig_data ? buf_wgt_i[1*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign weight_3_out = r_trig_data ? buf_wgt_i[2*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign weight_4_out = r_trig_data ? buf_wgt_i[3*DATA_WIDTH +: DATA_WIDTH] : '0;

endmodule

// File: tb/tb_mmu_seq.sv
// Randomized bench for mmu_seq: a per-tile schedule model predicts every output in every cycle
// from the accepted (k, mode, base) and the driven mmu_busy.
module tb_mmu_seq;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 10;
  localparam int unsigned KW    = 16;
  localparam int          DRAIN = 6;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b0;
  logic            start_i = 1'b0;
  logic            mode_i = 1'b0;
  logic [KW-1:0]   k_i = '0;
  logic [AW-1:0]   base_addr_i = '0;
  logic            ready_o, done_o, buf_rd_en_o;
  logic [AW-1:0]   buf_rd_addr_o;
  logic [4*DW-1:0] buf_data_i = '0;
  logic [4*DW-1:0] buf_wgt_i = '0;
  logic            mmu_cmd_valid;
  logic [4:0]      mmu_cmd;
  logic [DW-1:0]   param_1_out, param_2_out;
  logic [DW-1:0]   data_1_out, data_2_out, data_3_out, data_4_out;
  logic [DW-1:0]   weight_1_out, weight_2_out, weight_3_out, weight_4_out;
  logic            mmu_busy = 1'b0;

  mmu_seq dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .mode_i       (mode_i),
    .k_i          (k_i),
    .base_addr_i  (base_addr_i),
    .ready_o      (ready_o),
    .done_o       (done_o),
    .buf_rd_en_o  (buf_rd_en_o),
    .buf_rd_addr_o(buf_rd_addr_o),
    .buf_data_i   (buf_data_i),
    .buf_wgt_i    (buf_wgt_i),
    .mmu_cmd_valid(mmu_cmd_valid),
    .mmu_cmd      (mmu_cmd),
    .param_1_out  (param_1_out),
    .param_2_out  (param_2_out),
    .data_1_out   (data_1_out),
    .data_2_out   (data_2_out),
    .data_3_out   (data_3_out),
    .data_4_out   (data_4_out),
    .weight_1_out (weight_1_out),
    .weight_2_out (weight_2_out),
    .weight_3_out (weight_3_out),
    .weight_4_out (weight_4_out),
    .mmu_busy     (mmu_busy)
  );

  always #5 clk_i = ~clk_i;

  logic [4*DW-1:0] mem_d [1024];
  logic [4*DW-1:0] mem_w [1024];

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  // Reference model: one outstanding tile, described by its accept cycle and parameters.
  bit        m_act = 1'b0;
  int        m_a, m_k, m_base, m_done;
  bit        m_mode;
  bit        acc_flag, done_seen;
  bit        hold_req = 1'b0;
  bit        busy_rand = 1'b1;
  int        hold_from = 0;
  int        hold_to = 0;
  bit        rd_seen = 1'b0;
  logic [AW-1:0] addr_seen = '0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit m_idle();
    return !m_act || (m_done >= 0 && cyc > m_done);
  endfunction

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_ready"}, ready_o, 1);
    check_val({tag, "_done"}, done_o, 0);
    check_val({tag, "_rd"}, {buf_rd_en_o, buf_rd_addr_o}, 0);
    check_val({tag, "_cmd"}, {mmu_cmd_valid, mmu_cmd}, 6'h07);
    check_val({tag, "_data"}, {data_4_out, data_3_out, data_2_out, data_1_out}, 0);
    check_val({tag, "_wgt"}, {weight_4_out, weight_3_out, weight_2_out, weight_1_out}, 0);
    check_val({tag, "_param"}, {param_2_out, param_1_out}, 0);
  endtask

  task automatic check_cycle();
    bit            idle;
    int            t;
    logic          exp_rd, exp_valid;
    logic [AW-1:0] exp_addr;
    logic [2:0]    exp_cmd;
    logic [127:0]  exp_d, exp_w;
    logic [AW-1:0] a;
    idle      = m_idle();
    t         = cyc - m_a;
    exp_rd    = 1'b0;
    exp_addr  = '0;
    exp_valid = 1'b0;
    exp_cmd   = 3'd7;
    exp_d     = '0;
    exp_w     = '0;
    if (!idle) begin
      if (t == 1) begin
        exp_valid = 1'b1;
        exp_cmd   = m_mode ? 3'd5 : 3'd6;
      end else if (t == 2) begin
        exp_valid = 1'b1;
        exp_cmd   = 3'd0;
      end else if (m_k > 0) begin
        if (t >= 3 && t <= m_k + 2) begin
          exp_rd   = 1'b1;
          exp_addr = AW'(m_base + t - 3);
        end
        if (t >= 4 && t <= m_k + DRAIN + 3) begin
          exp_valid = 1'b1;
          exp_cmd   = 3'd1;
          if (t <= m_k + 3) begin
            a     = AW'(m_base + t - 4);
            exp_d = mem_d[a];
            exp_w = mem_w[a];
          end
        end
      end
    end
    check_val("ready", ready_o, idle);
    check_val("done", done_o, m_act && cyc == m_done);
    check_val("rd", {buf_rd_en_o, buf_rd_addr_o}, {exp_rd, exp_addr});
    check_val("cmd", {mmu_cmd_valid, mmu_cmd}, {exp_valid, 2'b00, exp_cmd});
    check_val("data", {data_4_out, data_3_out, data_2_out, data_1_out}, exp_d);
    check_val("wgt", {weight_4_out, weight_3_out, weight_2_out, weight_1_out}, exp_w);
    check_val("param", {param_2_out, param_1_out}, 0);
    if (done_o) done_seen = 1'b1;
    // Completion: first cycle after the flush with the MMU idle; done follows one cycle later.
    if (!idle && m_done < 0 && m_k > 0 && t >= m_k + DRAIN + 3 && !mmu_busy) m_done = cyc + 1;
    if (idle && start_i) begin
      m_act    = 1'b1;
      m_a      = cyc;
      m_k      = int'(k_i);
      m_mode   = mode_i;
      m_base   = int'(base_addr_i);
      m_done   = (k_i == '0) ? cyc + 3 : -1;
      acc_flag = 1'b1;
      if (hold_req) begin
        hold_from = cyc + m_k + DRAIN + 3;
        hold_to   = hold_from + 5;
      end
    end
    rd_seen   = buf_rd_en_o;
    addr_seen = buf_rd_addr_o;
  endtask

  task automatic tick();
    if (cyc >= hold_from && cyc < hold_to) mmu_busy = 1'b1;
    else if (busy_rand) mmu_busy = ($urandom_range(0, 3) == 0);
    else mmu_busy = 1'b0;
    #1;
    check_cycle();
    @(posedge clk_i);
    #1;
    cyc++;
    if (rd_seen) begin
      buf_data_i = mem_d[addr_seen];
      buf_wgt_i  = mem_w[addr_seen];
    end else begin
      buf_data_i = {$urandom(), $urandom(), $urandom(), $urandom()};
      buf_wgt_i  = {$urandom(), $urandom(), $urandom(), $urandom()};
    end
  endtask

  task automatic accept_tile(input int k, input bit mode, input int base, input bit hold);
    int budget;
    start_i     = 1'b1;
    k_i         = KW'(k);
    mode_i      = mode;
    base_addr_i = AW'(base);
    hold_req    = hold;
    acc_flag    = 1'b0;
    done_seen   = 1'b0;
    budget      = 0;
    while (!acc_flag && budget < 50) begin
      tick();
      budget++;
    end
    start_i     = 1'b0;
    hold_req    = 1'b0;
    k_i         = KW'($urandom());
    base_addr_i = AW'($urandom());
    mode_i      = 1'($urandom());
  endtask

  task automatic run_tile(input int k, input bit mode, input int base, input bit hold);
    int budget;
    accept_tile(k, mode, base, hold);
    budget = 0;
    while (!done_seen && budget < 300) begin
      tick();
      budget++;
    end
    check_val("done_seen", done_seen, 1);
    tick();
  endtask

  initial begin
    int budget;
    for (int i = 0; i < 1024; i++) begin
      mem_d[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
      mem_w[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
    end
    // Tile 1 operands: data columns 1..16, identity weights.
    for (int n = 0; n < 4; n++) begin
      for (int j = 0; j < 4; j++) begin
        mem_d[16 + n][32*j +: 32] = 32'(4 * n + j + 1);
        mem_w[16 + n][32*j +: 32] = (j == n) ? 32'd1 : 32'd0;
      end
    end

    #3;
    check_idle_outputs("rst");
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;

    run_tile(4, 1'b0, 'h010, 1'b0);
    run_tile(0, 1'b1, 'h155, 1'b0);
    run_tile(0, 1'b0, 'h2AA, 1'b0);
    run_tile(4, 1'b1, 'h3FE, 1'b0);
    run_tile(3, 1'b0, 'h123, 1'b1);

    // Reset in the middle of FEED, then a fresh k=2 tile.
    accept_tile(8, 1'b1, 'h040, 1'b0);
    repeat (4) tick();
    #2;
    rst_i = 1'b0;
    #1;
    check_idle_outputs("midrst");
    m_act   = 1'b0;
    rd_seen = 1'b0;
    @(posedge clk_i);
    #1;
    cyc++;
    rst_i = 1'b1;
    run_tile(2, 1'b0, 'h0F0, 1'b0);

    // start_i held high with k_i/base/mode changing every cycle.
    busy_rand = 1'b0;
    start_i   = 1'b1;
    repeat (70) begin
      k_i         = KW'($urandom_range(1, 5));
      base_addr_i = AW'($urandom());
      mode_i      = 1'($urandom());
      tick();
    end
    start_i = 1'b0;
    budget  = 0;
    while (!m_idle() && budget < 100) begin
      tick();
      budget++;
    end
    tick();
    busy_rand = 1'b1;

    repeat (20) run_tile($urandom_range(0, 12), 1'($urandom()), int'($urandom_range(0, 1023)), 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    $fatal(1, "watchdog");
  end

endmodule
